// File: rtl/score_bcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : score_bcd_scheduler
// Purpose  : Shares one iterative double-dabble binary-to-BCD converter
//            between two requesters: port 0 (current score) and port 1
//            (high score). Keeps the latest BCD result for each port and
//            selects which one drives the 4-digit seven-segment display,
//            based on game state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1         system clock
//   rst        in   1         synchronous active-high reset
//   req        in   2         per-port conversion request (hold until ack)
//   bin0       in   BIN_W     port-0 binary value (score)
//   bin1       in   BIN_W     port-1 binary value (high score)
//   ack        out  2         one-cycle pulse: port's bin captured
//   done       out  2         one-cycle pulse: port's BCD result updated
//   bcd0       out  4*DIGITS  latched BCD result, port 0
//   bcd1       out  4*DIGITS  latched BCD result, port 1
//   ovf        out  2         per-port flag: last value exceeded 10^DIGITS-1
//   state      in   2         game state: 00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   disp_bcd   out  4*DIGITS  value to display (registered)
//   disp_sel   out  1         0 = showing bcd0, 1 = showing bcd1
//   disp_blank out  DIGITS    per-digit blank mask (1 = blank)
// Configuration
//   SCORE_BCD_LEADING_BLANK_EN : when defined, leading zero digits above
//   digit 0 are blanked; otherwise disp_blank is tied to 0.
// ============================================================================
module score_bcd_scheduler #(
    parameter int BIN_W      = 16,
    parameter int DIGITS     = 4,
    parameter int ALT_PERIOD = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [BIN_W-1:0]    bin0,
    input  logic [BIN_W-1:0]    bin1,
    output logic [1:0]          ack,
    output logic [1:0]          done,
    output logic [4*DIGITS-1:0] bcd0,
    output logic [4*DIGITS-1:0] bcd1,
    output logic [1:0]          ovf,
    input  logic [1:0]          state,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic                disp_sel,
    output logic [DIGITS-1:0]   disp_blank
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(BIN_W + 1);
    localparam int c_ALT_W = $clog2(ALT_PERIOD + 1);
    localparam int c_CMP_W = (BIN_W > 32) ? BIN_W : 32;
    localparam logic [c_CMP_W-1:0] c_MAX_VAL = c_CMP_W'((10 ** DIGITS) - 1);
    localparam logic [c_BCD_W-1:0] c_SAT_VAL = {DIGITS{4'h9}};

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_SHIFT   = 2'd1;
    localparam logic [1:0] c_S_WB      = 2'd2;
    localparam logic [1:0] c_GAME_OVER = 2'b11;

    // Converter
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0]   r_shift;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic [c_BCD_W-1:0] w_bcd_next;
    logic [c_BCD_W-1:0] w_wb_val;
    logic               r_port;
    logic               r_last;
    logic [1:0]         r_ovf;
    logic [1:0]         r_done;
    logic [c_BCD_W-1:0] r_bcd0;
    logic [c_BCD_W-1:0] r_bcd1;
    logic               w_any_req;
    logic               w_grant_port;
    logic [1:0]         w_ack;
    logic [BIN_W-1:0]   w_bin_sel;
    logic               w_bin_ovf;
    logic               w_last_step;

    // Display
    logic [c_ALT_W-1:0] r_alt_cnt;
    logic               r_sel;
    logic [c_BCD_W-1:0] r_disp;
    logic [c_BCD_W-1:0] w_disp_next;

    // Round robin: with both requesting, the port not granted last wins.
    assign w_any_req    = |req;
    assign w_grant_port = (req == 2'b11) ? ~r_last : req[1];
    assign w_bin_sel    = w_grant_port ? bin1 : bin0;
    assign w_bin_ovf    = (c_CMP_W'(w_bin_sel) > c_MAX_VAL);
    assign w_last_step  = (r_cnt == c_CNT_W'(BIN_W - 1));

    // Double-dabble adjust: +3 on every nibble >= 5 before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                        ? r_bcd[4*gi +: 4] + 4'd3
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

    // The bit shifted out of the top is dropped; it can only be non-zero
    // for an overflowing value, which is saturated anyway.
    assign w_bcd_next = c_BCD_W'({w_bcd_adj, r_shift[BIN_W-1]});
    assign w_wb_val   = r_ovf[r_port] ? c_SAT_VAL : w_bcd_next;

    always_comb begin
        w_state_next = r_state;
        w_ack        = 2'b00;
        case (r_state)
            c_S_IDLE: begin
                if (w_any_req && !rst) begin
                    w_ack        = w_grant_port ? 2'b10 : 2'b01;
                    w_state_next = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (w_last_step) begin
                    w_state_next = c_S_WB;
                end
            end
            c_S_WB:  w_state_next = c_S_IDLE;
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // The result register is loaded on the edge that enters S_WB so that the
    // done pulse and the new bcd value are visible in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_ovf   <= 2'b00;
            r_done  <= 2'b00;
            r_bcd0  <= '0;
            r_bcd1  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 2'b00;
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_port                <= w_grant_port;
                        r_last                <= w_grant_port;
                        r_shift               <= w_bin_sel;
                        r_bcd                 <= '0;
                        r_cnt                 <= '0;
                        r_ovf[w_grant_port]   <= w_bin_ovf;
                    end
                end
                c_S_SHIFT: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (w_last_step) begin
                        r_done[r_port] <= 1'b1;
                        if (r_port) begin
                            r_bcd1 <= w_wb_val;
                        end else begin
                            r_bcd0 <= w_wb_val;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Alternation only runs in OVER; leaving OVER restarts it from bcd0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alt_cnt <= '0;
            r_sel     <= 1'b0;
            r_disp    <= '0;
        end else begin
            r_disp <= w_disp_next;
            if (state != c_GAME_OVER) begin
                r_alt_cnt <= '0;
                r_sel     <= 1'b0;
            end else if (r_alt_cnt == c_ALT_W'(ALT_PERIOD - 1)) begin
                r_alt_cnt <= '0;
                r_sel     <= ~r_sel;
            end else begin
                r_alt_cnt <= r_alt_cnt + c_ALT_W'(1);
            end
        end
    end

    assign w_disp_next = r_sel ? r_bcd1 : r_bcd0;

`ifdef SCORE_BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] w_blank_next;
    logic              w_zero_run;
    logic [DIGITS-1:0] r_blank;

    // Walk down from the top digit; blank while every digit so far is zero.
    always_comb begin
        w_blank_next = '0;
        w_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run      = w_zero_run & (w_disp_next[4*i +: 4] == 4'd0);
            w_blank_next[i] = w_zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= '0;
        end else begin
            r_blank <= w_blank_next;
        end
    end

    assign disp_blank = r_blank;
`else
    assign disp_blank = '0;
`endif

    assign ack      = w_ack;
    assign done     = r_done;
    assign bcd0     = r_bcd0;
    assign bcd1     = r_bcd1;
    assign ovf      = r_ovf;
    assign disp_bcd = r_disp;
    assign disp_sel = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_bcd_scheduler
// Purpose  : Directed, table-driven bench for score_bcd_scheduler with
//            hand-written sequences for arbitration, display alternation and
//            reset during a conversion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_bcd_scheduler;

    localparam int BIN_W      = 16;
    localparam int DIGITS     = 4;
    localparam int ALT_PERIOD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] bin0 = '0;
    logic [15:0] bin1 = '0;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic [15:0] bcd0;
    logic [15:0] bcd1;
    logic [1:0]  ovf;
    logic [1:0]  state = 2'b00;
    logic [15:0] disp_bcd;
    logic        disp_sel;
    logic [3:0]  disp_blank;

    score_bcd_scheduler #(
        .BIN_W      (BIN_W),
        .DIGITS     (DIGITS),
        .ALT_PERIOD (ALT_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .bin0       (bin0),
        .bin1       (bin1),
        .ack        (ack),
        .done       (done),
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .ovf        (ovf),
        .state      (state),
        .disp_bcd   (disp_bcd),
        .disp_sel   (disp_sel),
        .disp_blank (disp_blank)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] m_bcd0 = '0;
    logic [15:0] m_bcd1 = '0;
    logic [1:0]  m_ovf  = 2'b00;

    typedef struct {
        logic        port;
        logic [15:0] bin;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        logic [3:0]  exp_blank;   // blank mask for bcd0 after this vector
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_blank(input string name, input logic [3:0] exp);
`ifdef SCORE_BCD_LEADING_BLANK_EN
        check(name, disp_blank, exp);
`else
        check(name, disp_blank, 4'b0000);
`endif
    endtask

    task automatic do_conv(input logic port, input logic [15:0] value,
                           input logic [15:0] exp_bcd, input logic exp_ovf,
                           input logic [3:0] exp_blank);
        int k;
        @(negedge clk);
        if (port) bin1 = value; else bin0 = value;
        req = port ? 2'b10 : 2'b01;
        #1;
        check("ack_at_T", ack, port ? 2'b10 : 2'b01);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) req = 2'b00;
        end while (done[port] !== 1'b1 && k < 40);
        check("done_latency", k, 17);
        check("done_onehot", done, port ? 2'b10 : 2'b01);
        if (port) m_bcd1 = exp_bcd; else m_bcd0 = exp_bcd;
        m_ovf[port] = exp_ovf;
        check("bcd0", bcd0, m_bcd0);
        check("bcd1", bcd1, m_bcd1);
        check("ovf", ovf, m_ovf);
        @(negedge clk);
        check("done_pulse_end", done, 2'b00);
        check("disp_bcd", disp_bcd, m_bcd0);
        check("disp_sel", disp_sel, 1'b0);
        check_blank("disp_blank", exp_blank);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int got_done0;
        int got_ack1;
        int got_done1;
        int done_seen;
        logic exp_sel;
        logic [15:0] exp_d;

        vecs[0]  = '{1'b0, 16'd1234,  16'h1234, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 16'd12000, 16'h9999, 1'b1, 4'b0000};
        vecs[2]  = '{1'b0, 16'd12000, 16'h9999, 1'b1, 4'b0000};
        vecs[3]  = '{1'b0, 16'd42,    16'h0042, 1'b0, 4'b1100};
        vecs[4]  = '{1'b1, 16'd10000, 16'h9999, 1'b1, 4'b1100};
        vecs[5]  = '{1'b1, 16'd9999,  16'h9999, 1'b0, 4'b1100};
        vecs[6]  = '{1'b0, 16'd0,     16'h0000, 1'b0, 4'b1110};
        vecs[7]  = '{1'b0, 16'd65535, 16'h9999, 1'b1, 4'b0000};
        vecs[8]  = '{1'b1, 16'd8421,  16'h8421, 1'b0, 4'b0000};
        vecs[9]  = '{1'b0, 16'd10,    16'h0010, 1'b0, 4'b1100};
        vecs[10] = '{1'b1, 16'd500,   16'h0500, 1'b0, 4'b1100};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_bcd0", bcd0, 16'h0000);
        check("rst_bcd1", bcd1, 16'h0000);
        check("rst_ovf", ovf, 2'b00);
        check("rst_disp_bcd", disp_bcd, 16'h0000);
        check("rst_disp_sel", disp_sel, 1'b0);
        check("rst_disp_blank", disp_blank, 4'b0000);

        // Both ports requesting from reset: port 0 first, port 1 at T+18
        rst  = 1'b0;
        bin0 = 16'd7;
        bin1 = 16'd9999;
        req  = 2'b11;
        #1;
        check("rr_first_ack", ack, 2'b01);
        k = 0; got_done0 = -1; got_ack1 = -1; got_done1 = -1;
        while (k < 60 && got_done1 < 0) begin
            @(negedge clk);
            k++;
            if (k == 1) req = 2'b10;
            if (done[0] && got_done0 < 0) got_done0 = k;
            if (got_ack1 >= 0 && k == got_ack1 + 1) req = 2'b00;
            if (ack[1] && got_ack1 < 0) got_ack1 = k;
            if (done[1]) got_done1 = k;
        end
        check("rr_done0_cycle", got_done0, 17);
        check("rr_ack1_cycle", got_ack1, 18);
        check("rr_done1_cycle", got_done1, 35);
        m_bcd0 = 16'h0007;
        m_bcd1 = 16'h9999;
        check("rr_bcd0", bcd0, m_bcd0);
        check("rr_bcd1", bcd1, m_bcd1);
        check("rr_ovf", ovf, 2'b00);

        // Single-port conversions from the table
        for (int i = 0; i < 11; i++) begin
            do_conv(vecs[i].port, vecs[i].bin, vecs[i].exp_bcd,
                    vecs[i].exp_ovf, vecs[i].exp_blank);
        end

        // OVER alternation: bcd0=0010, bcd1=0500, ALT_PERIOD=4
        @(negedge clk);
        state = 2'b11;
        #1;
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) @(negedge clk);
            exp_sel = ((j / 4) % 2) == 1;
            if (j == 0) exp_d = m_bcd0;
            else        exp_d = (((j - 1) / 4) % 2 == 1) ? m_bcd1 : m_bcd0;
            check("alt_sel", disp_sel, exp_sel);
            check("alt_disp", disp_bcd, exp_d);
        end
        state = 2'b01;
        @(negedge clk);
        check("exit_over_sel", disp_sel, 1'b0);
        check("exit_over_disp", disp_bcd, m_bcd1);
        check_blank("exit_over_blank", 4'b1000);
        @(negedge clk);
        check("exit_over_disp2", disp_bcd, m_bcd0);
        check_blank("exit_over_blank2", 4'b1100);

        // Re-entering OVER restarts the alternation at bcd0
        state = 2'b11;
        #1;
        for (int j = 0; j <= 4; j++) begin
            if (j > 0) @(negedge clk);
            check("reenter_sel", disp_sel, (j == 4) ? 1'b1 : 1'b0);
        end
        state = 2'b00;
        repeat (2) @(negedge clk);

        // Reset during S_SHIFT aborts the conversion
        bin0 = 16'd1234;
        req  = 2'b01;
        #1;
        check("abort_ack", ack, 2'b01);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) req = 2'b00;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_done", done, 2'b00);
        check("abort_bcd0", bcd0, 16'h0000);
        check("abort_bcd1", bcd1, 16'h0000);
        check("abort_ovf", ovf, 2'b00);
        check("abort_disp_bcd", disp_bcd, 16'h0000);
        check("abort_disp_sel", disp_sel, 1'b0);
        check("abort_disp_blank", disp_blank, 4'b0000);
        rst = 1'b0;
        m_bcd0 = '0;
        m_bcd1 = '0;
        m_ovf  = 2'b00;
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done !== 2'b00) done_seen = 1;
        end
        check("abort_no_done", done_seen, 0);
        do_conv(1'b0, 16'd77, 16'h0077, 1'b0, 4'b1100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
